// File: rtl/uart_rx_os_if.sv
// Host-side interface of the oversampling UART receiver.
// Carries the received word, its status flags, the valid/ack handshake and
// the busy indicator.
//   master : receiver side (drives word, flags, valid, busy; samples ack)
//   slave  : host side (samples word, flags, valid, busy; drives ack)
interface uart_rx_os_if;
  logic [7:0] data;
  logic       valid;
  logic       ack;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output data, valid, parity_err, frame_err, overrun, busy,
    input  ack
  );

  modport slave (
    input  data, valid, parity_err, frame_err, overrun, busy,
    output ack
  );
endinterface

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver with start-glitch rejection, mid-bit
// sampling, parity/framing/overrun status and a single output register
// handed to the host through valid/ack.
// Ports:
//   clk, rst            : system clock, async active-high reset
//   os_div_i            : tick period minus 1 (bit = 16*(os_div_i+1) clk)
//   data_size_i         : 0 = 7 data bits, 1 = 8 data bits
//   parity_en_i         : parity bit follows the data
//   parity_mode_i       : 11 odd, 10 even, 01 mark, 00 space
//   stop_bit_size_i     : 0 = 1 stop bit, 1 = 2 stop bits
//   rx_i                : asynchronous serial line, idles high
//   host                : word, status, valid/ack handshake, busy
//
// state  | meaning
// IDLE   | waiting for a 1->0 transition on the synchronised line
// START  | counting to the start-bit midpoint to confirm the start
// DATA   | sampling data bits LSB-first at each bit midpoint
// PARITY | sampling and checking the parity bit
// STOP   | sampling one or two stop bits, then loading the output
module uart_rx_os #(
  parameter int OS_RATE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] os_div_i,
  input  logic        data_size_i,
  input  logic        parity_en_i,
  input  logic [1:0]  parity_mode_i,
  input  logic        stop_bit_size_i,
  input  logic        rx_i,
  uart_rx_os_if.master host
);
  localparam logic [3:0] SAMP_LAST = 4'(OS_RATE - 1);
  localparam logic [3:0] SAMP_MID  = 4'(OS_RATE / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_s_q, rx_prev_q;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [15:0] os_div_q, os_div_d;
  logic [3:0]  samp_q, samp_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_acc_q, par_acc_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        stop2_q, stop2_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        tick, samp_last, load;

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    os_div_d     = os_div_q;
    samp_d       = samp_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    par_acc_d    = par_acc_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    stop2_d      = stop2_q;
    data_d       = data_q;
    valid_d      = valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    tick         = 1'b0;
    load         = 1'b0;

    if (state_q != IDLE) begin
      if (tick_cnt_q == os_div_q) begin
        tick       = 1'b1;
        tick_cnt_d = '0;
      end else begin
        tick_cnt_d = tick_cnt_q + 16'd1;
      end
    end
    samp_last = tick && (samp_q == SAMP_LAST);

    unique case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        // Edge, not level: after a break the line must go high first.
        if (!rx_s_q && rx_prev_q) begin
          state_d   = START;
          os_div_d  = os_div_i;
          samp_d    = '0;
          bit_d     = '0;
          par_acc_d = parity_mode_i[0];
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
          stop2_d   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (samp_q == SAMP_MID) begin
            samp_d = '0;
            state_d = rx_s_q ? IDLE : DATA;
          end else begin
            samp_d = samp_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) samp_d = samp_q + 4'd1;
        if (samp_last) begin
          shreg_d   = {rx_s_q, shreg_q[7:1]};
          par_acc_d = par_acc_q ^ (rx_s_q & parity_mode_i[1]);
          bit_d     = bit_q + 3'd1;
          if (bit_q == (data_size_i ? 3'd7 : 3'd6))
            state_d = parity_en_i ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (tick) samp_d = samp_q + 4'd1;
        if (samp_last) begin
          perr_d  = (rx_s_q != par_acc_q);
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) samp_d = samp_q + 4'd1;
        if (samp_last) begin
          if (!rx_s_q) ferr_d = 1'b1;
          if (stop_bit_size_i && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load has priority over ack so a word arriving with ack is kept.
    if (load) begin
      data_d       = data_size_i ? shreg_q : {1'b0, shreg_q[7:1]};
      parity_err_d = perr_d;
      frame_err_d  = ferr_d;
      overrun_d    = valid_q & ~host.ack;
      valid_d      = 1'b1;
    end else if (valid_q && host.ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      tick_cnt_q   <= '0;
      os_div_q     <= '0;
      samp_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      par_acc_q    <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      stop2_q      <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_i;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      tick_cnt_q   <= tick_cnt_d;
      os_div_q     <= os_div_d;
      samp_q       <= samp_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      par_acc_q    <= par_acc_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      stop2_q      <= stop2_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign host.data       = data_q;
  assign host.valid      = valid_q;
  assign host.parity_err = parity_err_q;
  assign host.frame_err  = frame_err_q;
  assign host.overrun    = overrun_q;
  assign host.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: drives serial frames on rx and checks the
// host-side word, flags and handshake against hand-computed values.
module tb_uart_rx_os;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] os_div = 16'd3;
  logic        data_size = 1'b1;
  logic        parity_en = 1'b0;
  logic [1:0]  parity_mode = 2'b00;
  logic        stop_bit_size = 1'b0;
  logic        rx = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;

  uart_rx_os_if host_if ();

  uart_rx_os #(.OS_RATE(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .os_div_i        (os_div),
    .data_size_i     (data_size),
    .parity_en_i     (parity_en),
    .parity_mode_i   (parity_mode),
    .stop_bit_size_i (stop_bit_size),
    .rx_i            (rx),
    .host            (host_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
    end
  endtask

  function automatic int bit_period();
    return 16 * (int'(os_div) + 1);
  endfunction

  task automatic drive_bit(input logic b, input int cycles);
    @(negedge clk);
    rx = b;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input int nstop, input logic stop2_val);
    int bp;
    bp = bit_period();
    drive_bit(1'b0, bp);
    for (int i = 0; i < nbits; i++) drive_bit(d[i], bp);
    if (pen) drive_bit(pbit, bp);
    drive_bit(1'b1, bp);
    if (nstop == 2) drive_bit(stop2_val, bp);
    drive_bit(1'b1, 8);
  endtask

  task automatic do_ack();
    @(negedge clk);
    host_if.ack = 1'b1;
    @(negedge clk);
    host_if.ack = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [7:0] d, input logic pe,
                            input logic fe, input logic ov);
    check({tag, "_valid"}, 8'(host_if.valid), 8'h01);
    check({tag, "_data"}, host_if.data, d);
    check({tag, "_perr"}, 8'(host_if.parity_err), 8'(pe));
    check({tag, "_ferr"}, 8'(host_if.frame_err), 8'(fe));
    check({tag, "_ovr"}, 8'(host_if.overrun), 8'(ov));
    check({tag, "_busy"}, 8'(host_if.busy), 8'h00);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_data"}, host_if.data, 8'h00);
    check({tag, "_valid"}, 8'(host_if.valid), 8'h00);
    check({tag, "_perr"}, 8'(host_if.parity_err), 8'h00);
    check({tag, "_ferr"}, 8'(host_if.frame_err), 8'h00);
    check({tag, "_ovr"}, 8'(host_if.overrun), 8'h00);
    check({tag, "_busy"}, 8'(host_if.busy), 8'h00);
  endtask

  initial begin
    int bp;
    host_if.ack = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    bp = bit_period();

    // 8N1 0xA5 at 64 clk/bit
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    check_word("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    do_ack();
    check("a5_ack_valid", 8'(host_if.valid), 8'h00);
    check("a5_ack_data_kept", host_if.data, 8'hA5);

    // 7E1: 0x41 has two ones, so correct even parity bit is 0
    data_size = 1'b0; parity_en = 1'b1; parity_mode = 2'b10;
    send_frame(8'h41, 7, 1'b1, 1'b0, 1, 1'b1);
    check_word("7e1_ok", 8'h41, 1'b0, 1'b0, 1'b0);
    do_ack();
    send_frame(8'h41, 7, 1'b1, 1'b1, 1, 1'b1);
    check_word("7e1_bad", 8'h41, 1'b1, 1'b0, 1'b0);
    do_ack();

    // 8O1 0x07 (three ones): odd parity bit is 0
    data_size = 1'b1; parity_mode = 2'b11;
    send_frame(8'h07, 8, 1'b1, 1'b0, 1, 1'b1);
    check_word("8o1", 8'h07, 1'b0, 1'b0, 1'b0);
    do_ack();
    parity_en = 1'b0;

    // Glitch: 20 clk low; also checks 3-cycle rx-to-busy latency
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("lat_busy_early", 8'(host_if.busy), 8'h00);
    @(negedge clk);
    check("lat_busy", 8'(host_if.busy), 8'h01);
    repeat (17) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_busy", 8'(host_if.busy), 8'h00);
    check("glitch_valid", 8'(host_if.valid), 8'h00);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 1'b1);
    check_word("post_glitch", 8'hC3, 1'b0, 1'b0, 1'b0);
    do_ack();

    // Overrun
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
    check_word("ovr", 8'h22, 1'b0, 1'b0, 1'b1);
    do_ack();
    check("ovr_ack_valid", 8'(host_if.valid), 8'h00);
    check("ovr_flag_kept", 8'(host_if.overrun), 8'h01);
    send_frame(8'h33, 8, 1'b0, 1'b0, 1, 1'b1);
    check_word("after_ovr", 8'h33, 1'b0, 1'b0, 1'b0);
    do_ack();

    // Break: rx low for 12 bit times gives one frame of 0x00 with frame error
    @(negedge clk);
    rx = 1'b0;
    repeat (12 * bp) @(negedge clk);
    check_word("break", 8'h00, 1'b0, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    do_ack();

    // 8N2 with second stop bit low; left unacknowledged for the reset test
    stop_bit_size = 1'b1;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 2, 1'b0);
    check_word("8n2_ferr", 8'h3C, 1'b0, 1'b1, 1'b0);
    stop_bit_size = 1'b0;

    // Reset in the middle of data bit 3
    drive_bit(1'b0, bp);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, bp);
    drive_bit(1'b0, bp / 2);
    check("pre_rst_busy", 8'(host_if.busy), 8'h01);
    rst = 1'b1;
    rx = 1'b1;
    #1;
    check_reset("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
    check_word("post_rst", 8'h5A, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

16x-oversampling UART receiver that is the robust receive-side counterpart of `uart_tx`. It runs entirely in the `clk` domain, using a clock-enable tick rather than a derived clock. It shares the frame configuration of the transmitter (7/8 data bits, parity modes, 1/2 stop bits) and adds start-bit glitch rejection, mid-bit sampling, parity, framing and overrun status. Received words go to the host through a single output register with a valid/ack handshake.

## Interface
Parameters:
- `OS_RATE`, 16: oversample ticks per bit. Fixed at 16; other values are not supported.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `os_div`, in, 16: tick period minus 1, in `clk` cycles. Bit period = 16·(`os_div`+1) cycles.
- `data_size`, in, 1: 0 selects 7-bit data; 1 selects 8-bit data.
- `parity_en`, in, 1: 1 means a parity bit follows the data bits.
- `parity_mode`, in, 2: 11 odd; 10 even; 01 mark (1); 00 space (0).
- `stop_bit_size`, in, 1: 0 selects 1 stop bit; 1 selects 2 stop bits.
- `rx`, in, 1: serial line, asynchronous, idles high.
- `data`, out, 8: received word. Bit 7 reads 0 in 7-bit mode.
- `valid`, out, 1: `data` and the status flags hold an unacknowledged word.
- `ack`, in, 1: host consumes the word. Effective only when `valid` = 1.
- `parity_err`, out, 1: parity mismatch for the word in `data`.
- `frame_err`, out, 1: a stop bit was sampled 0 for the word in `data`.
- `overrun`, out, 1: the previous word was overwritten before it was acknowledged.
- `busy`, out, 1: a frame is in progress (state ≠ IDLE).

## Operation
- rx synchroniser: 2-flop, both flops reset to 1. The FSM sees only `rx_s`.
- Tick generator: counter counts 0..`os_div`. A one-cycle `tick` is produced at terminal count.
  - Counter is held at 0 in IDLE.
  - `os_div` is captured into an internal register on start detection. Changes to the port mid-frame have no effect.
- Sample counter (4 bits) and bit counter (3 bits) advance only on `tick`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when `rx_s` = 0, go to START. Clear the tick, sample and bit counters. Clear the parity accumulator to `parity_mode[0]`.
  - START: on the 8th tick (sample count 7, mid-bit), sample `rx_s`.
    - `rx_s` = 1: false start. Return to IDLE; nothing is reported.
    - `rx_s` = 0: clear the sample count and go to DATA.
  - DATA: on every 16th tick, sample and shift in LSB-first: `shreg <= {rx_s, shreg[7:1]}`. Also `par_acc ^= rx_s & parity_mode[1]`.
    - After 7 bits (`data_size` = 0) or 8 bits, go to PARITY if `parity_en`, else to STOP.
  - PARITY: on the 16th tick, set the parity error as `rx_s != par_acc`, then go to STOP. With `parity_en` = 0 the parity error is 0.
  - STOP: on the 16th tick, sample. A 0 sets the framing error.
    - If `stop_bit_size` = 1, take a second sample 16 ticks later. Either sample being 0 sets the framing error.
    - The cycle after the last stop sample is the load cycle. Return to IDLE at the stop-bit midpoint, so the receiver resynchronises on the next start edge.
- 7-bit alignment: at load, `data` = `shreg >> 1` if `data_size` = 0, else `shreg`.
- Load cycle actions:
  - `data`, `parity_err` and `frame_err` are updated together.
  - `overrun` <= `valid & ~ack`.
  - `valid` <= 1.
  - Words with errors are still delivered.
- Handshake:
  - `ack` while `valid` clears `valid` on the next edge.
  - `ack` while `valid` = 0 is ignored.
  - Load and `ack` in the same cycle: the load wins, `valid` stays 1, and `overrun` = 0.
  - Status flags are not cleared by `ack`; they are replaced only at the next load.

## Timing
- Reset values: `data` = 0x00, `valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0. FSM in IDLE, all counters 0.
- `rx` edge to `busy` high: 3 `clk` cycles (2 synchroniser cycles plus 1 FSM cycle).
- Data bit n is sampled 16·(n+1)+8 ticks after start detection (n = 0..7), within ±1 clk.
- `valid` rises 1 clk after the last stop-bit sample tick.
- `busy` falls in the same cycle that `valid` rises.
- `os_div` = 0 gives a tick every cycle (16 clk per bit, the minimum).
- `rst` mid-frame: immediate return to reset values. A partial frame is discarded. The synchroniser reads idle (1).
- `rx` held low continuously (break): yields one frame with `data` = 0x00 and `frame_err` = 1. The next frame starts only after `rx_s` is seen high in IDLE. IDLE requires a 1→0 transition; a level is not enough.

## Test plan
- `os_div` = 3, 8N1, send 0xA5 at 64 clk/bit. Expect `data` = 0xA5, `valid` = 1, `parity_err` = 0, `frame_err` = 0, `overrun` = 0. After `ack`, `valid` = 0.
- 7-bit, even parity, send 0x41 with parity bit 0. Expect `data` = 0x41 and `parity_err` = 0. Repeat with parity bit 1: expect `parity_err` = 1 and `data` = 0x41.
- Glitch: `rx` low for 20 clk (5 ticks) at `os_div` = 3. Expect `busy` to fall by tick 8, `valid` to stay 0, and the next valid frame to be received correctly.
- 8N2, send 0x3C with the second stop bit forced to 0. Expect `data` = 0x3C, `frame_err` = 1, `valid` = 1.
- Send 0x11 then 0x22 without `ack`. Expect `data` = 0x22 and `overrun` = 1. `ack` it, then send 0x33: expect `overrun` = 0.
- Assert `rst` at data bit 3 of a frame. Expect all outputs at reset values. A subsequent 0x5A is received cleanly.
